// File: rtl/vid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vid_pkg
// Description : Shared types and helpers for the video frame fetch path.
// Revision    : 1.0 - initial release
// ============================================================================
package vid_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_REQ       = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DONE      = 3'd4
    } fetch_state_e;

    // Number of 32-bit words in one active frame.
    function automatic int unsigned frame_words(input int unsigned h_active,
                                                input int unsigned v_active,
                                                input int unsigned bytes_per_pix);
        return (h_active * v_active * bytes_per_pix) / WORD_BYTES;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vid_frame_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : vid_frame_fetch_ctrl_if
// Description : Burst read request bus between the fetch controller and the
//               memory-side read master.
// Revision    : 1.0 - initial release
// ============================================================================
interface vid_frame_fetch_ctrl_if #(
    parameter int ADDR_W = 32
) ();

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_len;
    logic              rd_ack;
    logic              rd_done;

    modport master (
        output rd_req,
        output rd_addr,
        output rd_len,
        input  rd_ack,
        input  rd_done
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        input  rd_len,
        output rd_ack,
        output rd_done
    );

endinterface
`default_nettype wire

// File: rtl/vid_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : vid_sync_edge
// Description : Registered detector for the vs transition into its active
//               level; sof is a one-cycle pulse one cycle after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module vid_sync_edge #(
    parameter int VS_POL = 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic vs,
    output logic      sof
);

    localparam logic ACT_LVL = (VS_POL != 0);

    logic vs_q;
    logic vs_d;
    logic sof_q;
    logic sof_d;

    always_comb begin
        vs_d  = vs;
        sof_d = (vs == ACT_LVL) && (vs_q != ACT_LVL);
    end

    // History starts at the active level so a vs already active at reset
    // release is not mistaken for a fresh frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q  <= ACT_LVL;
            sof_q <= 1'b0;
        end else begin
            vs_q  <= vs_d;
            sof_q <= sof_d;
        end
    end

    assign sof = sof_q;

endmodule
`default_nettype wire

// File: rtl/vid_frame_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vid_frame_fetch_ctrl
// Description : Sequences fixed-size burst reads of a frame buffer into the
//               pixel line FIFO, restarting on every frame sync.
// Revision    : 1.0 - initial release
// ============================================================================
module vid_frame_fetch_ctrl
    import vid_pkg::*;
#(
    parameter int H_ACTIVE      = 1280,
    parameter int V_ACTIVE      = 720,
    parameter int BYTES_PER_PIX = 2,
    parameter int BURST_LEN     = 16,
    parameter int FIFO_DEPTH    = 512,
    parameter int ADDR_W        = 32,
    parameter int VS_POL        = 1,
    localparam int LVL_W        = $clog2(FIFO_DEPTH + 1)
) (
    input  wire logic              video_clk,
    input  wire logic              rst_n,
    input  wire logic              enable,
    input  wire logic [ADDR_W-1:0] frame_base,
    input  wire logic              vs,
    input  wire logic              de,
    input  wire logic [LVL_W-1:0]  fifo_level,
    vid_frame_fetch_ctrl_if.master rd,
    output logic                   fifo_flush,
    output logic                   frame_busy,
    output logic [15:0]            underflow_cnt
);

    localparam int unsigned FRAME_WORDS = frame_words(H_ACTIVE, V_ACTIVE, BYTES_PER_PIX);
    localparam int          CNT_W       = $clog2(FRAME_WORDS + 1);

    generate
        if (BURST_LEN > FIFO_DEPTH) begin : g_chk_burst_depth
            $error("BURST_LEN must not exceed FIFO_DEPTH");
        end
        if (BURST_LEN > 255) begin : g_chk_burst_width
            $error("BURST_LEN must fit the 8-bit rd_len field");
        end
        if (((H_ACTIVE * BYTES_PER_PIX) % 4) != 0) begin : g_chk_line_align
            $error("each line must be a whole number of 32-bit words");
        end
    endgenerate

    logic w_sof;

    vid_sync_edge #(
        .VS_POL (VS_POL)
    ) u_sync_edge (
        .clk   (video_clk),
        .rst_n (rst_n),
        .vs    (vs),
        .sof   (w_sof)
    );

    fetch_state_e      state_q,         state_d;
    logic [ADDR_W-1:0] base_q,          base_d;
    logic [CNT_W-1:0]  word_cnt_q,      word_cnt_d;
    logic              rd_req_q,        rd_req_d;
    logic [ADDR_W-1:0] rd_addr_q,       rd_addr_d;
    logic [7:0]        rd_len_q,        rd_len_d;
    logic              fifo_flush_q,    fifo_flush_d;
    logic              flush_dly_q,     flush_dly_d;
    logic              frame_busy_q,    frame_busy_d;
    logic              pending_sof_q,   pending_sof_d;
    logic              stop_q,          stop_d;
    logic [15:0]       underflow_cnt_q, underflow_cnt_d;

    logic [LVL_W-1:0]  w_level_eff;
    logic              w_room;
    logic [CNT_W-1:0]  w_remain;
    logic [7:0]        w_next_len;
    logic [ADDR_W-1:0] w_next_addr;
    logic [CNT_W-1:0]  w_cnt_after;
    logic              w_restart;

    // The FIFO level lags the flush, so it is ignored for two cycles.
    assign w_level_eff = (fifo_flush_q || flush_dly_q) ? '0 : fifo_level;
    assign w_room      = (32'(w_level_eff) + 32'(BURST_LEN)) <= 32'(FIFO_DEPTH);
    assign w_remain    = CNT_W'(FRAME_WORDS) - word_cnt_q;
    assign w_next_len  = (32'(w_remain) < 32'(BURST_LEN)) ? 8'(w_remain) : 8'(BURST_LEN);
    assign w_next_addr = base_q + (ADDR_W'(word_cnt_q) * ADDR_W'(WORD_BYTES));
    assign w_cnt_after = word_cnt_q + CNT_W'(rd_len_q);

    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        word_cnt_d      = word_cnt_q;
        rd_req_d        = rd_req_q;
        rd_addr_d       = rd_addr_q;
        rd_len_d        = rd_len_q;
        fifo_flush_d    = 1'b0;
        flush_dly_d     = fifo_flush_q;
        frame_busy_d    = frame_busy_q;
        pending_sof_d   = pending_sof_q;
        stop_d          = stop_q;
        underflow_cnt_d = underflow_cnt_q;
        w_restart       = 1'b0;

        if (de && (fifo_level == '0) && (underflow_cnt_q != 16'hFFFF)) begin
            underflow_cnt_d = underflow_cnt_q + 16'd1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (w_sof && enable) begin
                    w_restart = 1'b1;
                end
            end
            ST_CHECK: begin
                if (!enable) begin
                    state_d      = ST_IDLE;
                    frame_busy_d = 1'b0;
                end else if (w_sof) begin
                    w_restart = 1'b1;
                end else if (w_room) begin
                    state_d   = ST_REQ;
                    rd_req_d  = 1'b1;
                    rd_addr_d = w_next_addr;
                    rd_len_d  = w_next_len;
                end
            end
            ST_REQ: begin
                if (w_sof) begin
                    pending_sof_d = 1'b1;
                end
                if (!enable) begin
                    stop_d = 1'b1;
                end
                if (rd.rd_ack) begin
                    rd_req_d = 1'b0;
                    state_d  = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (w_sof) begin
                    pending_sof_d = 1'b1;
                end
                if (!enable) begin
                    stop_d = 1'b1;
                end
                if (rd.rd_done) begin
                    word_cnt_d = w_cnt_after;
                    if (stop_q || !enable) begin
                        state_d       = ST_IDLE;
                        frame_busy_d  = 1'b0;
                        pending_sof_d = 1'b0;
                        stop_d        = 1'b0;
                    end else if (pending_sof_q || w_sof) begin
                        pending_sof_d = 1'b0;
                        w_restart     = 1'b1;
                    end else if (w_cnt_after == CNT_W'(FRAME_WORDS)) begin
                        state_d      = ST_DONE;
                        frame_busy_d = 1'b0;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_restart) begin
            base_d       = frame_base;
            word_cnt_d   = '0;
            fifo_flush_d = 1'b1;
            frame_busy_d = 1'b1;
            state_d      = ST_CHECK;
        end
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            base_q          <= '0;
            word_cnt_q      <= '0;
            rd_req_q        <= 1'b0;
            rd_addr_q       <= '0;
            rd_len_q        <= '0;
            fifo_flush_q    <= 1'b0;
            flush_dly_q     <= 1'b0;
            frame_busy_q    <= 1'b0;
            pending_sof_q   <= 1'b0;
            stop_q          <= 1'b0;
            underflow_cnt_q <= '0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            word_cnt_q      <= word_cnt_d;
            rd_req_q        <= rd_req_d;
            rd_addr_q       <= rd_addr_d;
            rd_len_q        <= rd_len_d;
            fifo_flush_q    <= fifo_flush_d;
            flush_dly_q     <= flush_dly_d;
            frame_busy_q    <= frame_busy_d;
            pending_sof_q   <= pending_sof_d;
            stop_q          <= stop_d;
            underflow_cnt_q <= underflow_cnt_d;
        end
    end

    assign rd.rd_req     = rd_req_q;
    assign rd.rd_addr    = rd_addr_q;
    assign rd.rd_len     = rd_len_q;
    assign fifo_flush    = fifo_flush_q;
    assign frame_busy    = frame_busy_q;
    assign underflow_cnt = underflow_cnt_q;

endmodule
`default_nettype wire

// File: doc/vid_frame_fetch_ctrl.md
Name: vid_frame_fetch_ctrl

Overview:
- Sequences frame-buffer reads for the HDMI/DVI output path.
- On each frame sync from the video timing generator it restarts at the frame base address.
- Issues fixed-size word-burst read requests to the memory-side read master, one burst outstanding at a time, whenever the pixel line FIFO has room; the data lands in that FIFO and the pixel side drains it during DE.
- Tracks frame progress, flushes stale FIFO data at frame start and counts pixel underflows.

Parameters:
- H_ACTIVE, 1280, active pixels per line.
- V_ACTIVE, 720, active lines per frame.
- BYTES_PER_PIX, 2, bytes per pixel (RGB565).
- BURST_LEN, 16, maximum 32-bit words per read burst.
- FIFO_DEPTH, 512, line FIFO depth in 32-bit words.
- ADDR_W, 32, byte address width.
- VS_POL, 1, active level of vs (1 = active-high).
- Derived localparams:
  - FRAME_WORDS = H_ACTIVE*V_ACTIVE*BYTES_PER_PIX/4 = 460800.
  - CNT_W = $clog2(FRAME_WORDS+1).
  - LVL_W = $clog2(FIFO_DEPTH+1).

Ports:
- video_clk  in  1  pixel clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  fetch enable.
- frame_base  in  ADDR_W  byte base address of the frame; sampled at frame start only.
- vs  in  1  vertical sync from the timing generator.
- de  in  1  pixel data enable, used for underflow detection.
- fifo_level  in  LVL_W  current line FIFO fill, in words.
- rd_req  out  1  burst read request.
- rd_addr  out  ADDR_W  burst start byte address.
- rd_len  out  8  burst length in words.
- rd_ack  in  1  request accepted (one-cycle pulse).
- rd_done  in  1  last word of the burst written into the FIFO (one-cycle pulse).
- fifo_flush  out  1  one-cycle FIFO clear pulse.
- frame_busy  out  1  frame fetch in progress.
- underflow_cnt  out  16  saturating underflow count.

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0, state IDLE, word_cnt 0, pending_sof 0.
- Frame start (sof) is the vs transition into VS_POL, detected against a one-cycle-delayed copy of vs. sof is one cycle after the vs edge.
- States: IDLE, CHECK, REQ, WAIT_DONE, DONE.
- IDLE, or DONE, with sof and enable=1:
  - latch base_q=frame_base, word_cnt=0;
  - fifo_flush=1 for exactly one cycle;
  - frame_busy=1;
  - go to CHECK.
- CHECK:
  - If enable=0: go to IDLE, frame_busy=0.
  - Else if FIFO_DEPTH - fifo_level >= BURST_LEN: go to REQ. The fifo_level in the flush cycle and the cycle after is treated as 0.
  - Else stay.
- REQ:
  - rd_req=1; rd_addr = base_q + word_cnt*4 (modulo 2^ADDR_W); rd_len = min(BURST_LEN, FRAME_WORDS - word_cnt).
  - rd_req, rd_addr and rd_len stay stable until rd_ack.
  - rd_req drops the cycle after rd_ack is sampled high; go to WAIT_DONE.
  - rd_req is never withdrawn without rd_ack.
- WAIT_DONE: on rd_done, word_cnt += rd_len. Then, in priority order:
  - pending_sof set: clear pending_sof, restart the frame exactly as IDLE+sof (flush, reload).
  - word_cnt == FRAME_WORDS: go to DONE, frame_busy=0.
  - otherwise: go to CHECK.
- sof arriving in REQ or WAIT_DONE sets pending_sof; the outstanding burst always completes first.
- sof arriving in CHECK restarts immediately (flush, reload, stay CHECK).
- sof in DONE or IDLE with enable=0 is ignored.
- enable deasserted in REQ or WAIT_DONE: the burst completes, then go to IDLE. pending_sof is cleared.
- rd_done outside WAIT_DONE and rd_ack outside REQ are ignored.
- Minimum request spacing: 2 cycles from rd_done to the next rd_req (WAIT_DONE, then CHECK, then REQ).
- Underflow: when de=1 and fifo_level=0 in the same cycle, underflow_cnt increments by 1. It saturates at 16'hFFFF and clears only on reset.
- Elaboration-time checks:
  - BURST_LEN <= FIFO_DEPTH;
  - BURST_LEN <= 255;
  - (H_ACTIVE*BYTES_PER_PIX) % 4 == 0.

Decomposition:
- Shared package vid_pkg: FSM state enum, word size constant (4 bytes), and an FRAME_WORDS computation function reused by the timing and fetch blocks.
- One natural sub-module: vid_sync_edge (polarity-configurable edge detector producing sof). Everything else stays in one module.

Test Plan:
- Small config (H_ACTIVE=8, V_ACTIVE=2, BURST_LEN=4, FIFO_DEPTH=8), frame_base=32'h1000, fifo_level=0, sof; ack and done each burst -> fifo_flush once, then bursts at rd_addr 32'h1000 then 32'h1010, rd_len=4 each, frame_busy falls after the 2nd rd_done, state DONE.
- FIFO nearly full: fifo_level=5 (free 3 < 4) -> rd_req stays 0; set fifo_level=4 -> rd_req asserts on the 2nd cycle.
- rd_ack delayed 10 cycles -> rd_req, rd_addr, rd_len held constant for all 10 cycles; rd_req low the cycle after ack.
- sof mid-burst in WAIT_DONE -> no new rd_req before rd_done; then fifo_flush pulse and next rd_addr = new frame_base with rd_len=4.
- Default params, FRAME_WORDS=460800 words -> last rd_addr = base+0x1C2000-0x40, final rd_len=16, 28800 bursts total.
- de=1 with fifo_level=0 for 3 cycles -> underflow_cnt=3; force 70000 cycles -> saturates at 16'hFFFF; async rst_n pulse mid-burst -> all outputs 0 immediately.
